// File: rtl/bsr_segmented_chain_if.sv
// Boundary-scan chain bus: the TAP-side controls and serial data plus the
// system-side parallel boundary and status.
//   master : TAP / test side (drives strobes, tdi, parallel_in)
//   slave  : the segmented chain (drives tdo, parallel_out, seg_en, chain_len)
interface bsr_segmented_chain_if #(
  parameter int NUM_SEG   = 4,
  parameter int SEG_WIDTH = 32,
  parameter int LEN_W     = $clog2(NUM_SEG*SEG_WIDTH+1)
);
  logic                           chain_sel;
  logic                           capture_dr;
  logic                           shift_dr;
  logic                           update_dr;
  logic                           mode;
  logic                           tdi;
  logic                           tdo;
  logic [NUM_SEG*SEG_WIDTH-1:0]   parallel_in;
  logic [NUM_SEG*SEG_WIDTH-1:0]   parallel_out;
  logic [NUM_SEG-1:0]             seg_en;
  logic [LEN_W-1:0]               chain_len;

  modport master (
    output chain_sel, capture_dr, shift_dr, update_dr, mode, tdi, parallel_in,
    input  tdo, parallel_out, seg_en, chain_len
  );
  modport slave (
    input  chain_sel, capture_dr, shift_dr, update_dr, mode, tdi, parallel_in,
    output tdo, parallel_out, seg_en, chain_len
  );
endinterface

// File: rtl/bsr_segmented_chain.sv
// Segmented boundary-scan register with runtime segment bypass.
//   tck  : scan clock, all state on rising edge
//   trst : async active-low reset
//   bus  : slave side of bsr_segmented_chain_if (strobes, tdi/tdo,
//          parallel boundary, committed enable mask, current chain length)
// Data chain: tdi -> seg 0 -> ... -> seg NUM_SEG-1 -> tdo. A disabled segment
// is replaced by a single bypass flop. chain_sel=1 selects the NUM_SEG-bit
// configuration register whose update commits seg_en.

// One boundary segment: shift stage, update latch and bypass flop.
module bsr_seg #(
  parameter int SEG_WIDTH = 32
) (
  input  logic                 i_tck,
  input  logic                 i_trst,
  input  logic                 i_en,
  input  logic                 i_cap,
  input  logic                 i_shift,
  input  logic                 i_upd,
  input  logic                 i_mode,
  input  logic                 i_si,
  input  logic [SEG_WIDTH-1:0] i_pin,
  output logic                 o_so,
  output logic [SEG_WIDTH-1:0] o_pout
);
  logic [SEG_WIDTH-1:0] r_shift;
  logic [SEG_WIDTH-1:0] r_upd;
  logic                 r_byp;

  always_ff @(posedge i_tck or negedge i_trst) begin
    if (!i_trst) begin
      r_shift <= '0;
      r_upd   <= '0;
      r_byp   <= 1'b0;
    end else begin
      if (i_cap) begin
        if (i_en) r_shift <= i_pin;
        r_byp <= 1'b0;
      end else if (i_shift) begin
        // disabled segment keeps its shift stage; only the bypass flop moves
        if (i_en) r_shift <= {i_si, r_shift[SEG_WIDTH-1:1]};
        else      r_byp   <= i_si;
      end
      // samples pre-edge shift contents even when shifting this cycle
      if (i_upd && i_en) r_upd <= r_shift;
    end
  end

  assign o_so   = i_en ? r_shift[0] : r_byp;
  assign o_pout = (i_en && i_mode) ? r_upd : i_pin;
endmodule

module bsr_segmented_chain #(
  parameter int                 NUM_SEG   = 4,
  parameter int                 SEG_WIDTH = 32,
  parameter logic [NUM_SEG-1:0] RESET_EN  = {NUM_SEG{1'b1}},
  parameter int                 LEN_W     = $clog2(NUM_SEG*SEG_WIDTH+1)
) (
  input  logic                    tck,
  input  logic                    trst,
  bsr_segmented_chain_if.slave    bus
);
  logic [NUM_SEG-1:0]                r_seg_en;
  logic [NUM_SEG-1:0]                r_cfg;
  logic [NUM_SEG:0]                  w_chain;
  logic [NUM_SEG-1:0][SEG_WIDTH-1:0] w_pin;
  logic [NUM_SEG-1:0][SEG_WIDTH-1:0] w_pout;
  logic [LEN_W-1:0]                  w_len;

  // capture wins over shift; update is independent
  logic w_cap_d, w_shift_d, w_upd_d, w_cap_c, w_shift_c, w_upd_c;
  assign w_cap_d   = bus.capture_dr & ~bus.chain_sel;
  assign w_shift_d = bus.shift_dr & ~bus.capture_dr & ~bus.chain_sel;
  assign w_upd_d   = bus.update_dr & ~bus.chain_sel;
  assign w_cap_c   = bus.capture_dr & bus.chain_sel;
  assign w_shift_c = bus.shift_dr & ~bus.capture_dr & bus.chain_sel;
  assign w_upd_c   = bus.update_dr & bus.chain_sel;

  assign w_pin      = bus.parallel_in;
  assign w_chain[0] = bus.tdi;

  for (genvar g = 0; g < NUM_SEG; g++) begin : g_seg
    bsr_seg #(.SEG_WIDTH(SEG_WIDTH)) u_seg (
      .i_tck  (tck),
      .i_trst (trst),
      .i_en   (r_seg_en[g]),
      .i_cap  (w_cap_d),
      .i_shift(w_shift_d),
      .i_upd  (w_upd_d),
      .i_mode (bus.mode),
      .i_si   (w_chain[g]),
      .i_pin  (w_pin[g]),
      .o_so   (w_chain[g+1]),
      .o_pout (w_pout[g])
    );
  end

  // configuration chain and committed enable mask
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      r_cfg    <= '0;
      r_seg_en <= RESET_EN;
    end else begin
      if (w_cap_c)        r_cfg <= r_seg_en;
      else if (w_shift_c) r_cfg <= {bus.tdi, r_cfg[NUM_SEG-1:1]};
      if (w_upd_c)        r_seg_en <= r_cfg;
    end
  end

  always_comb begin
    w_len = '0;
    for (int i = 0; i < NUM_SEG; i++)
      w_len = w_len + (r_seg_en[i] ? LEN_W'(SEG_WIDTH) : LEN_W'(1));
  end

  assign bus.tdo          = bus.chain_sel ? r_cfg[0] : w_chain[NUM_SEG];
  assign bus.parallel_out = w_pout;
  assign bus.seg_en       = r_seg_en;
  assign bus.chain_len    = w_len;
endmodule

// File: tb/tb_bsr_segmented_chain.sv
// Directed bench for bsr_segmented_chain at NUM_SEG=4, SEG_WIDTH=8.
module tb_bsr_segmented_chain;
  localparam int NS = 4;
  localparam int SW = 8;
  localparam int LW = $clog2(NS*SW+1);

  logic tck = 1'b0;
  logic trst;
  int   n_vec = 0;
  int   n_err = 0;

  bsr_segmented_chain_if #(.NUM_SEG(NS), .SEG_WIDTH(SW), .LEN_W(LW)) bus();

  bsr_segmented_chain #(.NUM_SEG(NS), .SEG_WIDTH(SW), .LEN_W(LW)) dut (
    .tck (tck),
    .trst(trst),
    .bus (bus)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge, outputs sampled there too
  task automatic tick();
    @(posedge tck); #1;
  endtask

  task automatic shift_bit(input logic b);
    bus.shift_dr = 1'b1; bus.tdi = b;
    tick();
    bus.shift_dr = 1'b0;
  endtask

  task automatic shift_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) shift_bit(v[i]);
  endtask

  task automatic strobe_cap();
    bus.capture_dr = 1'b1; tick(); bus.capture_dr = 1'b0;
  endtask

  task automatic strobe_upd();
    bus.update_dr = 1'b1; tick(); bus.update_dr = 1'b0;
  endtask

  logic [31:0] got;

  initial begin
    trst = 1'b0;
    bus.chain_sel = 1'b0; bus.capture_dr = 1'b0; bus.shift_dr = 1'b0;
    bus.update_dr = 1'b0; bus.mode = 1'b0; bus.tdi = 1'b0;
    bus.parallel_in = 32'h12345678;
    tick(); tick();

    // 1. reset state
    chk("rst_tdo",    bus.tdo, 1'b0);
    chk("rst_seg_en", bus.seg_en, 4'b1111);
    chk("rst_len",    bus.chain_len, 32);
    chk("rst_pout_m0", bus.parallel_out, 32'h12345678);
    bus.mode = 1'b1; #1;
    chk("rst_pout_m1", bus.parallel_out, 32'h00000000);
    trst = 1'b1;
    tick();

    // 2. capture then shift out
    bus.parallel_in = 32'hDDCCBBAA;
    strobe_cap();
    for (int i = 0; i < 32; i++) begin
      got[i] = bus.tdo;
      shift_bit(1'b0);
    end
    chk("cap_b0", got[7:0],   8'hDD);
    chk("cap_b1", got[15:8],  8'hCC);
    chk("cap_b2", got[23:16], 8'hBB);
    chk("cap_b3", got[31:24], 8'hAA);
    chk("cap_tdo_empty", bus.tdo, 1'b0);
    bus.mode = 1'b0; #1;
    chk("cap_pass", bus.parallel_out, 32'hDDCCBBAA);
    bus.mode = 1'b1;
    strobe_upd();
    chk("cap_upd_zero", bus.parallel_out, 32'h00000000);

    // 3. config load and readback
    bus.chain_sel = 1'b1;
    shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b0);
    strobe_upd();
    chk("cfg_seg_en", bus.seg_en, 4'b0101);
    chk("cfg_len",    bus.chain_len, 18);
    strobe_cap();
    chk("cfg_rb0", bus.tdo, 1'b1); shift_bit(1'b0);
    chk("cfg_rb1", bus.tdo, 1'b0); shift_bit(1'b0);
    chk("cfg_rb2", bus.tdo, 1'b1); shift_bit(1'b0);
    chk("cfg_rb3", bus.tdo, 1'b0); shift_bit(1'b0);
    chk("cfg_hold_en", bus.seg_en, 4'b0101);

    // 4. bypassed load: deepest position first (byp3, seg2, byp1, seg0)
    bus.chain_sel = 1'b0; bus.mode = 1'b1; bus.parallel_in = 32'hFFFFFFFF;
    shift_bit(1'b0);      // bypass 3
    shift_byte(8'hA5);    // seg 2
    shift_bit(1'b1);      // bypass 1
    shift_byte(8'h3C);    // seg 0
    chk("byp_tdo18", bus.tdo, 1'b0);
    strobe_upd();
    chk("byp_pout", bus.parallel_out, 32'hFFA5FF3C);
    for (int i = 0; i < 9; i++) shift_bit(1'b0);
    chk("byp_tdo27", bus.tdo, 1'b1);

    // 5. update overlapping shift samples pre-edge contents
    bus.chain_sel = 1'b1;
    shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b0);
    strobe_upd();
    chk("ovl_len", bus.chain_len, 11);
    bus.chain_sel = 1'b0;
    shift_byte(8'h81);
    bus.shift_dr = 1'b1; bus.update_dr = 1'b1; bus.tdi = 1'b0;
    tick();
    bus.shift_dr = 1'b0; bus.update_dr = 1'b0;
    chk("ovl_pout", bus.parallel_out, 32'hFFFFFF81);
    strobe_upd();
    chk("ovl_pout_next", bus.parallel_out, 32'hFFFFFF40);

    // 6. async reset mid-shift, no tck edge involved
    for (int i = 0; i < 10; i++) shift_bit(1'b1);
    #2 trst = 1'b0;
    #1;
    chk("mid_seg_en", bus.seg_en, 4'b1111);
    chk("mid_len",    bus.chain_len, 32);
    chk("mid_pout",   bus.parallel_out, 32'h00000000);
    chk("mid_tdo",    bus.tdo, 1'b0);
    trst = 1'b1;
    tick();
    strobe_upd();
    chk("mid_upd_zero", bus.parallel_out, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
